// File: rtl/tensor_core_sequencer_if.sv
// rtl/tensor_core_sequencer_if.sv - byte-serial command and result streams of the tensor core sequencer
interface tensor_core_sequencer_if #(
  parameter int ELEM_W = 8
) ();
  logic              in_valid;
  logic [ELEM_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [ELEM_W-1:0] out_data;
  logic              out_ready;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/tensor_core_sequencer.sv
// rtl/tensor_core_sequencer.sv - loads 3x3 operands, starts the core, returns its result; TENSOR_CORE_SEQ_HEADER_ECHO_EN prepends the op beat
module tensor_core_sequencer #(
  parameter int ELEM_W         = 8,
  parameter int COMPUTE_CYCLES = 5
) (
  input  logic                          tensor_core_clock,
  input  logic                          tensor_core_reset,
  tensor_core_sequencer_if.slave        stream,
  output logic [2:0][2:0][ELEM_W-1:0]   core_input1,
  output logic [2:0][2:0][ELEM_W-1:0]   core_input2,
  output logic                          core_write_enable,
  output logic                          core_start,
  output logic [1:0]                    core_operation_select,
  input  logic [2:0][2:0][ELEM_W-1:0]   core_output,
  output logic                          busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_A  = 3'd1;
  localparam logic [2:0] S_LOAD_B  = 3'd2;
  localparam logic [2:0] S_START   = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_CAPTURE = 3'd5;
  localparam logic [2:0] S_DRAIN   = 3'd6;

  localparam int CNT_W = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES + 1) : 1;

`ifdef TENSOR_CORE_SEQ_HEADER_ECHO_EN
  localparam logic [3:0] LAST_IDX = 4'd9;
`else
  localparam logic [3:0] LAST_IDX = 4'd8;
`endif

  logic [2:0]             state;
  logic [3:0]             idx;
  logic [CNT_W-1:0]       cnt;
  logic [1:0]             op;
  // Row-major flat storage: element idx sits at [idx/3][idx%3] of the packed 3x3 view.
  logic [8:0][ELEM_W-1:0] mat_a;
  logic [8:0][ELEM_W-1:0] mat_b;
  logic [8:0][ELEM_W-1:0] res;

  always_ff @(posedge tensor_core_clock) begin
    if (tensor_core_reset) begin
      state <= S_IDLE;
      idx   <= '0;
      cnt   <= '0;
      op    <= '0;
      mat_a <= '0;
      mat_b <= '0;
      res   <= '0;
    end else begin
      case (state)
        S_IDLE: if (stream.in_valid) begin
          op    <= stream.in_data[1:0];
          idx   <= '0;
          state <= S_LOAD_A;
        end
        S_LOAD_A: if (stream.in_valid) begin
          mat_a[idx] <= stream.in_data;
          if (idx == 4'd8) begin
            idx   <= '0;
            state <= S_LOAD_B;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        S_LOAD_B: if (stream.in_valid) begin
          mat_b[idx] <= stream.in_data;
          if (idx == 4'd8) begin
            idx   <= '0;
            state <= S_START;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        S_START: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == CNT_W'(COMPUTE_CYCLES - 1)) state <= S_CAPTURE;
          else                                   cnt   <= cnt + 1'b1;
        end
        S_CAPTURE: begin
          res   <= core_output;
          idx   <= '0;
          state <= S_DRAIN;
        end
        S_DRAIN: if (stream.out_ready) begin
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= S_IDLE;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    stream.in_ready   = (state == S_IDLE) || (state == S_LOAD_A) || (state == S_LOAD_B);
    core_write_enable = stream.in_ready;
    stream.out_valid  = (state == S_DRAIN);
    stream.out_last   = (state == S_DRAIN) && (idx == LAST_IDX);
    core_start        = (state == S_START);
    busy              = (state != S_IDLE);
`ifdef TENSOR_CORE_SEQ_HEADER_ECHO_EN
    stream.out_data   = (idx == 4'd0) ? {{(ELEM_W-2){1'b0}}, op} : res[idx - 4'd1];
`else
    stream.out_data   = res[idx];
`endif
  end

  assign core_input1           = mat_a;
  assign core_input2           = mat_b;
  assign core_operation_select = op;

endmodule

// File: tb/tb_tensor_core_sequencer.sv
// tb/tb_tensor_core_sequencer.sv - scoreboard bench for tensor_core_sequencer with a behavioural 3x3 core
module tb_tensor_core_sequencer;
  localparam int W = 8;
  localparam int C = 5;

  typedef logic [2:0][2:0][W-1:0] mat_t;

  logic tensor_core_clock = 1'b0;
  logic tensor_core_reset = 1'b1;
  mat_t core_input1, core_input2, core_output;
  logic core_write_enable, core_start, busy;
  logic [1:0] core_operation_select;

  tensor_core_sequencer_if #(.ELEM_W(W)) bus ();

  tensor_core_sequencer #(.ELEM_W(W), .COMPUTE_CYCLES(C)) dut (
    .tensor_core_clock     (tensor_core_clock),
    .tensor_core_reset     (tensor_core_reset),
    .stream                (bus.slave),
    .core_input1           (core_input1),
    .core_input2           (core_input2),
    .core_write_enable     (core_write_enable),
    .core_start            (core_start),
    .core_operation_select (core_operation_select),
    .core_output           (core_output),
    .busy                  (busy)
  );

  always #5 tensor_core_clock = ~tensor_core_clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;
  int last_b_cycle = 0;
  int start_cnt = 0;
  bit first_beat = 0;
  bit stalled = 0;
  bit bp = 0;
  logic [W-1:0] held_data;
  logic [W:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic mat_t core_fn(input mat_t a, input mat_t b, input logic [1:0] op);
    mat_t r;
    logic signed [W-1:0] acc;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        if (op[1]) r[i][j] = $signed(a[i][j]) < 0 ? '0 : a[i][j];
        else if (op[0]) r[i][j] = a[i][j] + b[i][j];
        else begin
          acc = '0;
          for (int k = 0; k < 3; k++) acc = acc + $signed(a[i][k]) * $signed(b[k][j]);
          r[i][j] = acc;
        end
      end
    return r;
  endfunction

  // Behavioural tensor core: result appears a clock after start, well inside the compute window.
  always @(posedge tensor_core_clock) begin
    cycle++;
    if (core_start) core_output <= core_fn(core_input1, core_input2, core_operation_select);
  end

  always @(negedge tensor_core_clock) begin
    if (!tensor_core_reset) begin
      if (core_start) start_cnt++;
      if (stalled) check("stall_hold", {bus.out_valid, bus.out_data}, {1'b1, held_data});
      stalled = 0;
      if (bus.out_valid) begin
        if (first_beat) begin
          check("latency", cycle - last_b_cycle, C + 2);
          first_beat = 0;
        end
        if (bus.out_ready) begin
          if (sb_q.size() == 0) check("unexpected_beat", 1, 0);
          else check("beat", {bus.out_last, bus.out_data}, sb_q.pop_front());
        end else begin
          stalled   = 1;
          held_data = bus.out_data;
        end
      end
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge tensor_core_clock);
      #1;
      bus.out_ready = bp ? ~bus.out_ready : 1'b1;
    end
  end

  task automatic send_byte(input logic [W-1:0] b, input int gap);
    int n;
    repeat (gap) @(posedge tensor_core_clock);
    if (gap > 0) #1;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    @(negedge tensor_core_clock);
    while (!bus.in_ready && n < 50) begin
      @(negedge tensor_core_clock);
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 0, 1);
    @(posedge tensor_core_clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_packet(input logic [W-1:0] hdr, input mat_t a, input mat_t b,
                             input bit gapped, input int b_beats);
    mat_t r;
    start_cnt = 0;
    send_byte(hdr, 0);
    for (int i = 0; i < 9; i++) send_byte(a[i/3][i%3], gapped ? i % 2 : 0);
    for (int i = 0; i < b_beats; i++) send_byte(b[i/3][i%3], gapped ? (i + 1) % 2 : 0);
    if (b_beats == 9) begin
      last_b_cycle = cycle;
      r = core_fn(a, b, hdr[1:0]);
`ifdef TENSOR_CORE_SEQ_HEADER_ECHO_EN
      sb_q.push_back({1'b0, {(W-2){1'b0}}, hdr[1:0]});
`endif
      for (int i = 0; i < 9; i++) sb_q.push_back({i == 8, r[i/3][i%3]});
      first_beat = 1;
      check("in_ready_after_load", bus.in_ready, 0);
      check("we_after_load", core_write_enable, 0);
      check("start_pulse_now", core_start, 1);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 300) begin
      @(posedge tensor_core_clock);
      n++;
    end
    @(posedge tensor_core_clock);
    #1;
    check("drain_timeout", sb_q.size(), 0);
    check("start_pulses", start_cnt, 1);
    check("idle_after_drain", busy, 0);
  endtask

  mat_t ma, mb;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    core_output  = '0;
    repeat (3) @(posedge tensor_core_clock);
    #1;
    check("rst_busy", busy, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_we", core_write_enable, 1);
    check("rst_start", core_start, 0);
    check("rst_op", core_operation_select, 0);
    check("rst_operands", 32'(core_input1 != '0 || core_input2 != '0), 0);
    tensor_core_reset = 1'b0;
    @(posedge tensor_core_clock);
    #1;

    // 1: identity x 1..9
    for (int i = 0; i < 9; i++) begin
      ma[i/3][i%3] = (i % 4 == 0) ? 8'd1 : 8'd0;
      mb[i/3][i%3] = W'(i + 1);
    end
    send_packet(8'h00, ma, mb, 0, 9);
    wait_drain();

    // 2: add 3 + -5
    for (int i = 0; i < 9; i++) begin
      ma[i/3][i%3] = 8'd3;
      mb[i/3][i%3] = 8'hFB;
    end
    send_packet(8'h01, ma, mb, 0, 9);
    wait_drain();

    // 3: relu of alternating signs
    for (int i = 0; i < 9; i++) begin
      ma[i/3][i%3] = (i % 2 == 0) ? W'(-(i + 1)) : W'(i + 1);
      mb[i/3][i%3] = 8'd0;
    end
    send_packet(8'h02, ma, mb, 0, 9);
    wait_drain();

    // 4: test-1 data under output backpressure and gapped input
    for (int i = 0; i < 9; i++) begin
      ma[i/3][i%3] = (i % 4 == 0) ? 8'd1 : 8'd0;
      mb[i/3][i%3] = W'(i + 1);
    end
    bp = 1;
    send_packet(8'h00, ma, mb, 1, 9);
    wait_drain();
    bp = 0;

    // 5: reset after five matrix-2 beats, then a clean packet
    send_packet(8'h00, ma, mb, 0, 5);
    tensor_core_reset = 1'b1;
    @(posedge tensor_core_clock);
    #1;
    tensor_core_reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_we", core_write_enable, 1);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_operands", 32'(core_input1 != '0), 0);
    send_packet(8'h00, ma, mb, 0, 9);
    wait_drain();

    // Random matmul with upper header bits set (must be ignored), plus random add
    for (int i = 0; i < 9; i++) begin
      ma[i/3][i%3] = W'($urandom_range(0, 255));
      mb[i/3][i%3] = W'($urandom_range(0, 255));
    end
    send_packet(8'hFC, ma, mb, 0, 9);
    wait_drain();
    check("op_ignores_upper", core_operation_select, 2'b00);
    send_packet(8'hA1, ma, mb, 1, 9);
    wait_drain();

    repeat (5) @(posedge tensor_core_clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
